prbs_ber_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 31 +++
 rtl/prbs_lfsr.sv | 38 +++
 rtl/prbs_ber_checker.sv | 272 +++++++++++++++++++++++++++
 tb/tb_prbs_ber_checker.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS checker and the upstream PRBS generator:
//   - prbs_state_e      : checker state encoding (SEED / VERIFY / LOCKED)
//   - prbs_tap()        : second feedback tap for each supported LFSR order
//   - prbs_width_legal(): true only for the supported orders 7, 15, 23, 31
// -----------------------------------------------------------------------------
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Second tap T of x^W + x^T + 1; 0 marks an unsupported order.
  function automatic int prbs_tap(input int width);
    case (width)
      32'd7:   return 32'd6;
      32'd15:  return 32'd14;
      32'd23:  return 32'd18;
      32'd31:  return 32'd28;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit prbs_width_legal(input int width);
    return (prbs_tap(width) != 32'd0);
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// -----------------------------------------------------------------------------
// prbs_lfsr
// Combinational next-bit / next-state logic for a Fibonacci PRBS LFSR of
// order WIDTH (taps from prbs_pkg). Shared by the checker and the generator.
//   state_i    : current LFSR contents, bit 0 is the newest bit
//   load_i     : 1 = shift in load_bit_i (seeding), 0 = free-run on pred_o
//   load_bit_i : external bit shifted in while loading
//   pred_o     : predicted next PRBS bit, s[W-1] ^ s[T-1]
//   next_o     : next LFSR contents
// -----------------------------------------------------------------------------
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int WIDTH = 31
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic             load_i,
  input  logic             load_bit_i,
  output logic             pred_o,
  output logic [WIDTH-1:0] next_o
);

  localparam int TAP     = prbs_tap(WIDTH);
  // Illegal orders are rejected by the instantiating module; keep the index
  // in range so elaboration reaches that check instead of failing here.
  localparam int TAP_IDX = (TAP > 32'd0) ? (TAP - 32'd1) : 32'd0;

  // Feedback prediction and shift selection.
  always_comb begin
    pred_o = state_i[WIDTH-1] ^ state_i[TAP_IDX];
    if (load_i) begin
      next_o = {state_i[WIDTH-2:0], load_bit_i};
    end else begin
      next_o = {state_i[WIDTH-2:0], pred_o};
    end
  end

endmodule

// File: rtl/prbs_ber_checker.sv
// -----------------------------------------------------------------------------
// prbs_ber_checker
// Self-synchronising PRBS bit-error-rate checker. Seeds a local LFSR from the
// received stream, verifies LOCK_COUNT predicted bits, then free-runs and
// counts checked bits and bit errors. Too many errors inside one WINDOW of
// valid bits drops lock and restarts seeding.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   in_valid      : in_bit is meaningful; when low all state holds
//   in_bit        : received serial bit
//   clear         : synchronous clear of bit_count / error_count (wins over
//                   a same-cycle count event; lock state unaffected)
//   locked        : high while LOCKED
//   error_pulse   : one-cycle pulse after a mismatched valid bit while LOCKED
//   bit_count     : saturating count of valid bits checked while LOCKED
//   error_count   : saturating count of mismatches while LOCKED
//   inverted      : (PRBS_POLARITY_DETECT_EN only) stream polarity is inverted
// Build option: define PRBS_POLARITY_DETECT_EN to add inverted-stream
// detection and the `inverted` output.
// -----------------------------------------------------------------------------
module prbs_ber_checker
  import prbs_pkg::*;
#(
  parameter int PRBS_WIDTH  = 31,
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 16,
  parameter int CNT_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] error_count
`ifdef PRBS_POLARITY_DETECT_EN
  ,
  output logic             inverted
`endif
);

  if (!prbs_width_legal(PRBS_WIDTH)) begin : g_illegal_width
    $error("prbs_ber_checker: PRBS_WIDTH must be 7, 15, 23 or 31");
  end

  localparam int SEED_W  = $clog2(PRBS_WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int ERR_W   = $clog2(LOSS_THRESH + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_WIDTH - 1);
  localparam logic [SEED_W-1:0]  SEED_ONE   = SEED_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]   WIN_ONE    = WIN_W'(1);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(LOSS_THRESH - 1);
  localparam logic [ERR_W-1:0]   ERR_ONE    = ERR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  prbs_state_e              state_q, state_d;
  logic [PRBS_WIDTH-1:0]    lfsr_q, lfsr_d, lfsr_next_s;
  logic [SEED_W-1:0]        seed_cnt_q, seed_cnt_d;
  logic [MATCH_W-1:0]       match_cnt_q, match_cnt_d;
  logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0]         win_err_q, win_err_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;
  logic                     locked_q, locked_d;
  logic                     err_pulse_q, err_pulse_d;

  logic pred_s, rx_bit_s, mism_s, loss_s, seed_done_s, win_end_s;
  logic inv_s, inv_run_s, polarity_hold_s, polarity_flip_s;

`ifdef PRBS_POLARITY_DETECT_EN
  logic [MATCH_W-1:0] inv_cnt_q, inv_cnt_d;
  logic               inverted_q, inverted_d;
  logic               mism_run_s;

  // An inverted stream mismatches every prediction, so a run of LOCK_COUNT
  // mismatches from the first VERIFY bit flips the receive polarity.
  always_comb begin
    inv_s           = inverted_q;
    inv_run_s       = (inv_cnt_q != '0);
    mism_run_s      = (state_q == VERIFY) && mism_s && (match_cnt_q == '0);
    polarity_flip_s = mism_run_s && (inv_cnt_q == MATCH_LAST);
    polarity_hold_s = mism_run_s && !polarity_flip_s;
  end

  // Polarity-run counter and polarity flag next state.
  always_comb begin
    inv_cnt_d  = inv_cnt_q;
    inverted_d = inverted_q;
    if (in_valid) begin
      if (polarity_hold_s) begin
        inv_cnt_d = inv_cnt_q + MATCH_ONE;
      end else begin
        inv_cnt_d = '0;
      end
      if (polarity_flip_s) begin
        inverted_d = ~inverted_q;
      end else begin
        inverted_d = inverted_q;
      end
    end else begin
      inv_cnt_d  = inv_cnt_q;
      inverted_d = inverted_q;
    end
  end

  // Polarity registers; only reset clears the detected polarity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inv_cnt_q  <= '0;
      inverted_q <= 1'b0;
    end else begin
      inv_cnt_q  <= inv_cnt_d;
      inverted_q <= inverted_d;
    end
  end

  assign inverted = inverted_q;
`else
  assign inv_s           = 1'b0;
  assign inv_run_s       = 1'b0;
  assign polarity_hold_s = 1'b0;
  assign polarity_flip_s = 1'b0;
`endif

  assign rx_bit_s = in_bit ^ inv_s;

  prbs_lfsr #(
    .WIDTH (PRBS_WIDTH)
  ) u_lfsr (
    .state_i    (lfsr_q),
    .load_i     (state_q != LOCKED),
    .load_bit_i (rx_bit_s),
    .pred_o     (pred_s),
    .next_o     (lfsr_next_s)
  );

  assign mism_s      = rx_bit_s ^ pred_s;
  assign seed_done_s = (state_q == SEED) && (seed_cnt_q == SEED_LAST);
  assign win_end_s   = (win_cnt_q == WIN_LAST);
  assign loss_s      = (state_q == LOCKED) && mism_s && (win_err_q == ERR_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; transitions happen only on valid bits.
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        SEED: begin
          if (seed_done_s) state_d = VERIFY;
          else             state_d = SEED;
        end
        VERIFY: begin
          if (!mism_s) begin
            // A match after a mismatch run is neither polarity: reseed.
            if (inv_run_s)                        state_d = SEED;
            else if (match_cnt_q == MATCH_LAST)   state_d = LOCKED;
            else                                  state_d = VERIFY;
          end else if (polarity_hold_s) begin
            state_d = VERIFY;
          end else begin
            state_d = SEED;
          end
        end
        LOCKED: begin
          if (loss_s) state_d = SEED;
          else        state_d = LOCKED;
        end
        default: state_d = SEED;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and registered-output next values.
  always_comb begin
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    locked_d    = (state_d == LOCKED);
    if (in_valid) begin
      lfsr_d = lfsr_next_s;
      if ((state_q == SEED) && !seed_done_s) seed_cnt_d = seed_cnt_q + SEED_ONE;
      else                                  seed_cnt_d = '0;
      if ((state_q == VERIFY) && !mism_s)   match_cnt_d = match_cnt_q + MATCH_ONE;
      else                                  match_cnt_d = '0;
      if ((state_q == LOCKED) && !loss_s) begin
        if (win_end_s) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_ONE;
          win_err_d = mism_s ? (win_err_q + ERR_ONE) : win_err_q;
        end
      end else begin
        win_cnt_d = '0;
        win_err_d = '0;
      end
      if ((state_q == LOCKED) && (bit_cnt_q != CNT_MAX)) bit_cnt_d = bit_cnt_q + CNT_ONE;
      else                                               bit_cnt_d = bit_cnt_q;
      if ((state_q == LOCKED) && mism_s && (err_cnt_q != CNT_MAX)) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      err_pulse_d = (state_q == LOCKED) && mism_s;
    end else begin
      err_pulse_d = 1'b0;
    end
    // Clear overrides any same-cycle count event.
    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_d;
      err_cnt_d = err_cnt_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked      = locked_q;
  assign error_pulse = err_pulse_q;
  assign bit_count   = bit_cnt_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_ber_checker
// Directed bench: DUT "a" is the default PRBS31 checker, DUT "b" is a PRBS7
// checker with 4-bit counters for saturation, zero-seed and polarity cases.
// The bench generates its own reference PRBS streams.
// -----------------------------------------------------------------------------
module tb_prbs_ber_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        a_valid, a_bit, a_clear, a_locked, a_pulse;
  logic [63:0] a_bits, a_errs;
  logic        b_valid, b_bit, b_clear, b_locked, b_pulse;
  logic [3:0]  b_bits, b_errs;
`ifdef PRBS_POLARITY_DETECT_EN
  logic        a_inv, b_inv;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [30:0] gen31;
  logic [6:0]  gen7;

  prbs_ber_checker #(
    .PRBS_WIDTH(31), .LOCK_COUNT(64), .WINDOW(256), .LOSS_THRESH(16), .CNT_W(64)
  ) u_dut_a (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_bit(a_bit),
    .clear(a_clear), .locked(a_locked), .error_pulse(a_pulse),
    .bit_count(a_bits), .error_count(a_errs)
`ifdef PRBS_POLARITY_DETECT_EN
    , .inverted(a_inv)
`endif
  );

  prbs_ber_checker #(
    .PRBS_WIDTH(7), .LOCK_COUNT(64), .WINDOW(256), .LOSS_THRESH(16), .CNT_W(4)
  ) u_dut_b (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_bit(b_bit),
    .clear(b_clear), .locked(b_locked), .error_pulse(b_pulse),
    .bit_count(b_bits), .error_count(b_errs)
`ifdef PRBS_POLARITY_DETECT_EN
    , .inverted(b_inv)
`endif
  );

  // Reference PRBS31 (x^31+x^28+1) and PRBS7 (x^7+x^6+1) generators.
  task automatic next31(output logic b);
    b = gen31[30] ^ gen31[27];
    gen31 = {gen31[29:0], b};
  endtask

  task automatic next7(output logic b);
    b = gen7[6] ^ gen7[5];
    gen7 = {gen7[5:0], b};
  endtask

  // Present one cycle of input, then sample 1 time unit after the edge.
  task automatic a_step(input logic v, input logic bt, input logic clr);
    a_valid = v; a_bit = bt; a_clear = clr;
    @(posedge clock); #1;
  endtask

  task automatic b_step(input logic v, input logic bt, input logic clr);
    b_valid = v; b_bit = bt; b_clear = clr;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; a_bit = 1'b0; a_clear = 1'b0;
    b_valid = 1'b0; b_bit = 1'b0; b_clear = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Feed n clean PRBS31 bits to DUT a; returns the 1-based index of the bit
  // after which locked was first seen high (0 if never).
  task automatic a_clean(input int n, output int first_lock);
    logic b;
    first_lock = 0;
    for (int i = 1; i <= n; i++) begin
      next31(b);
      a_step(1'b1, b, 1'b0);
      if (first_lock == 0 && a_locked) first_lock = i;
    end
  endtask

  task automatic b_clean(input int n, output int first_lock);
    logic b;
    first_lock = 0;
    for (int i = 1; i <= n; i++) begin
      next7(b);
      b_step(1'b1, b, 1'b0);
      if (first_lock == 0 && b_locked) first_lock = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_valid = 1'b0; a_bit = 1'b0; a_clear = 1'b0;
    b_valid = 1'b0; b_bit = 1'b0; b_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({a_locked, a_pulse, a_bits, a_errs} !== 130'd0) begin
      tests_failed++;
      $display("FAIL reset_a: locked=%0b pulse=%0b bits=%0d errs=%0d, expected all 0",
               a_locked, a_pulse, a_bits, a_errs);
    end
    tests_run++;
    if ({b_locked, b_pulse, b_bits, b_errs} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_b: locked=%0b pulse=%0b bits=%0d errs=%0d, expected all 0",
               b_locked, b_pulse, b_bits, b_errs);
    end
`ifdef PRBS_POLARITY_DETECT_EN
    tests_run++;
    if ({a_inv, b_inv} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_inverted: got %0b%0b expected 00", a_inv, b_inv);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    int first_lock, lost, pulses;
    logic b;
    do_reset();
    gen31 = 31'h2ACE1357;
    first_lock = 0; lost = 0; pulses = 0;
    for (int i = 1; i <= 10000; i++) begin
      next31(b);
      a_step(1'b1, b, 1'b0);
      if (first_lock == 0 && a_locked) first_lock = i;
      if (first_lock != 0 && !a_locked) lost++;
      if (a_pulse) pulses++;
    end
    tests_run++;
    if (first_lock !== 95) begin
      tests_failed++;
      $display("FAIL clean_lock_latency: locked after bit %0d, expected 95", first_lock);
    end
    tests_run++;
    if (lost !== 0) begin
      tests_failed++;
      $display("FAIL clean_lock_held: %0d unlocked cycles after lock, expected 0", lost);
    end
    tests_run++;
    if (a_bits !== 64'd9905 || a_errs !== 64'd0 || pulses !== 0) begin
      tests_failed++;
      $display("FAIL clean_counts: bits=%0d errs=%0d pulses=%0d, expected 9905/0/0",
               a_bits, a_errs, pulses);
    end
  endtask

  task automatic test_isolated_errors();
    int bad_cycles, first_bad, pulses, lost;
    logic b, err;
    bad_cycles = 0; first_bad = -1; pulses = 0; lost = 0;
    for (int i = 0; i < 500; i++) begin
      next31(b);
      err = ((i % 100) == 10);
      a_step(1'b1, b ^ err, 1'b0);
      if (a_pulse) pulses++;
      if (!a_locked) lost++;
      if (a_pulse !== err) begin
        bad_cycles++;
        if (first_bad < 0) first_bad = i;
      end
    end
    tests_run++;
    if (bad_cycles !== 0) begin
      tests_failed++;
      $display("FAIL isolated_pulse_timing: %0d wrong cycles (first at %0d), expected 0",
               bad_cycles, first_bad);
    end
    tests_run++;
    if (a_errs !== 64'd5 || pulses !== 5) begin
      tests_failed++;
      $display("FAIL isolated_error_count: errs=%0d pulses=%0d, expected 5/5", a_errs, pulses);
    end
    tests_run++;
    if (lost !== 0 || a_bits !== 64'd10405) begin
      tests_failed++;
      $display("FAIL isolated_lock_bits: unlocked=%0d bits=%0d, expected 0/10405", lost, a_bits);
    end
  endtask

  task automatic test_burst();
    int first_lock;
    logic b, locked_at_15;
    do_reset();
    gen31 = 31'h13579BDF;
    a_clean(95, first_lock);
    locked_at_15 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      next31(b);
      a_step(1'b1, ~b, 1'b0);
      if (k == 15) locked_at_15 = a_locked;
    end
    tests_run++;
    if (first_lock !== 95 || locked_at_15 !== 1'b1 || a_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_loss: lock@%0d locked_after_15=%0b locked_after_16=%0b, expected 95/1/0",
               first_lock, locked_at_15, a_locked);
    end
    tests_run++;
    if (a_errs !== 64'd16 || a_bits !== 64'd16 || a_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL burst_counts: errs=%0d bits=%0d pulse=%0b, expected 16/16/1",
               a_errs, a_bits, a_pulse);
    end
    a_clean(95, first_lock);
    tests_run++;
    if (first_lock !== 95 || a_errs !== 64'd16 || a_bits !== 64'd16) begin
      tests_failed++;
      $display("FAIL burst_relock: relock after %0d bits errs=%0d bits=%0d, expected 95/16/16",
               first_lock, a_errs, a_bits);
    end
  endtask

  task automatic test_window_wrap();
    int first_lock, lost;
    logic b, err;
    do_reset();
    gen31 = 31'h0F0F1234;
    a_clean(95, first_lock);
    lost = 0;
    // 15 errors in the first window, 15 more early in the second one.
    for (int i = 1; i <= 300; i++) begin
      next31(b);
      err = (i <= 15) || (i > 256 && i <= 271);
      a_step(1'b1, b ^ err, 1'b0);
      if (!a_locked) lost++;
    end
    tests_run++;
    if (lost !== 0 || a_errs !== 64'd30) begin
      tests_failed++;
      $display("FAIL window_wrap_hold: unlocked=%0d errs=%0d, expected 0/30", lost, a_errs);
    end
    next31(b);
    a_step(1'b1, ~b, 1'b0);
    tests_run++;
    if (a_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL window_wrap_loss: locked=%0b after 16th error in window, expected 0", a_locked);
    end
  endtask

  task automatic test_gaps_clear();
    int first_lock, n_valid, pulses;
    logic b;
    do_reset();
    gen31 = 31'h7654321;
    a_clean(95, first_lock);
    n_valid = 0; pulses = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        next31(b);
        a_step(1'b1, b, 1'b0);
        n_valid++;
      end else begin
        a_step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (a_pulse) pulses++;
    end
    tests_run++;
    if (a_bits !== 64'(n_valid) || a_errs !== 64'd0 || pulses !== 0 || a_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_counts: bits=%0d errs=%0d pulses=%0d locked=%0b, expected %0d/0/0/1",
               a_bits, a_errs, pulses, a_locked, n_valid);
    end
    next31(b);
    a_step(1'b1, ~b, 1'b1);
    tests_run++;
    if (a_errs !== 64'd0 || a_bits !== 64'd0 || a_pulse !== 1'b1 || a_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_on_error: errs=%0d bits=%0d pulse=%0b locked=%0b, expected 0/0/1/1",
               a_errs, a_bits, a_pulse, a_locked);
    end
    next31(b);
    a_step(1'b1, b, 1'b0);
    a_step(1'b0, ~b, 1'b0);
    tests_run++;
    if (a_bits !== 64'd1 || a_errs !== 64'd0 || a_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL count_after_clear: bits=%0d errs=%0d pulse=%0b, expected 1/0/0",
               a_bits, a_errs, a_pulse);
    end
  endtask

  task automatic test_reset_midlock();
    int first_lock;
    logic was_locked;
    was_locked = a_locked;
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if (was_locked !== 1'b1 || {a_locked, a_pulse, a_bits, a_errs} !== 130'd0) begin
      tests_failed++;
      $display("FAIL reset_midlock: before=%0b locked=%0b bits=%0d errs=%0d, expected 1/0/0/0",
               was_locked, a_locked, a_bits, a_errs);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    a_clean(95, first_lock);
    tests_run++;
    if (first_lock !== 95) begin
      tests_failed++;
      $display("FAIL relock_after_reset: locked after %0d bits, expected 95", first_lock);
    end
  endtask

  task automatic test_zero_seed();
    int first_lock;
    logic zero_locked;
    do_reset();
    zero_locked = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b_step(1'b1, 1'b0, 1'b0);
      if (b_locked) zero_locked = 1'b1;
    end
    b_step(1'b1, 1'b1, 1'b0);
    gen7 = 7'h5B;
    b_clean(71, first_lock);
    tests_run++;
    if (zero_locked !== 1'b0 || first_lock !== 71) begin
      tests_failed++;
      $display("FAIL zero_seed: locked_on_zeros=%0b lock after %0d bits, expected 0/71",
               zero_locked, first_lock);
    end
  endtask

  task automatic test_saturation();
    int first_lock;
    logic b;
    b_clean(20, first_lock);
    tests_run++;
    if (b_bits !== 4'd15 || b_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate_bits: bits=%0d locked=%0b, expected 15/1", b_bits, b_locked);
    end
    for (int k = 0; k < 16; k++) begin
      next7(b);
      b_step(1'b1, ~b, 1'b0);
    end
    tests_run++;
    if (b_errs !== 4'd15 || b_bits !== 4'd15 || b_locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL saturate_errs: errs=%0d bits=%0d locked=%0b, expected 15/15/0",
               b_errs, b_bits, b_locked);
    end
  endtask

  task automatic test_polarity();
    int locked_cycles, first_lock, first_inv;
    logic b;
    do_reset();
    gen7 = 7'h11;
    locked_cycles = 0; first_lock = 0; first_inv = 0;
    for (int i = 1; i <= 300; i++) begin
      next7(b);
      b_step(1'b1, ~b, 1'b0);
      if (b_locked) locked_cycles++;
      if (first_lock == 0 && b_locked) first_lock = i;
`ifdef PRBS_POLARITY_DETECT_EN
      if (first_inv == 0 && b_inv) first_inv = i;
`endif
    end
`ifdef PRBS_POLARITY_DETECT_EN
    tests_run++;
    if (first_inv !== 71 || first_lock !== 142) begin
      tests_failed++;
      $display("FAIL polarity_detect: inverted after %0d lock after %0d, expected 71/142",
               first_inv, first_lock);
    end
    tests_run++;
    if (b_locked !== 1'b1 || b_errs !== 4'd0 || b_inv !== 1'b1) begin
      tests_failed++;
      $display("FAIL polarity_locked: locked=%0b errs=%0d inv=%0b, expected 1/0/1",
               b_locked, b_errs, b_inv);
    end
`else
    tests_run++;
    if (locked_cycles !== 0 || b_errs !== 4'd0 || first_inv !== 0) begin
      tests_failed++;
      $display("FAIL inverted_no_lock: locked cycles=%0d errs=%0d, expected 0/0",
               locked_cycles, b_errs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_isolated_errors();
    test_burst();
    test_window_wrap();
    test_gaps_clear();
    test_reset_midlock();
    test_zero_seed();
    test_saturation();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
